spi_slave: RTL and testbench

//  SPI slave endpoint sitting directly downstream of spi_master: consumes spi_clk/cs/mosi
//  and returns miso. Oversamples the SPI pins with the system clock, deserialises received

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 34 +++
 rtl/spi_slave.sv | 143 ++++++++++++++
 tb/tb_spi_slave.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// spi_pkg: shared state encodings and default word width for the SPI slave.
// Rev 1.0
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// spi_sync: multi-stage synchroniser for one asynchronous pin with rise/fall pulses.
// Rev 1.0
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              level;

  // Reset to 0 so a pin already low when reset releases never reads as a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// spi_slave: mode-0 SPI slave endpoint, oversampled by clk, MSB first, cs active-low.
// Rev 1.0
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic [1:0]            state
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_sync;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  tx_buf;
  logic                   reload;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  reload_word;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_clk),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (cs),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi shares the spi_clk latency so the sampled bit lines up with the rise pulse.
  always_ff @(posedge clk) begin
    if (reset) mosi_chain <= '0;
    else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = LOAD;
      LOAD:    state_d = cs_rise ? IDLE : SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

  // A word boundary inside SHIFT is the falling edge that follows the last rise (bit_cnt wrapped).
  assign reload = !cs_rise &&
                  ((state_q == LOAD) || (state_q == SHIFT && sck_fall && bit_cnt == '0));
  assign accept = tx_load && tx_ready;

  always_comb begin
    reload_word = '0;
    if (!tx_ready)    reload_word = tx_buf;
    else if (tx_load) reload_word = tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso     <= 1'b0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_buf   <= '0;
    end else begin
      rx_valid <= 1'b0;

      if (reload) begin
        tx_shift <= reload_word;
        miso     <= reload_word[DATA_WIDTH-1];
        tx_ready <= 1'b1;
        if (tx_ready && !tx_load) underrun <= 1'b1;
        if (state_q == LOAD) bit_cnt <= '0;
      end else if (accept) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end

      if (state_q != IDLE && cs_rise) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else if (sck_fall && bit_cnt != '0) begin
          tx_shift <= tx_shift << 1;
          miso     <= tx_shift[DATA_WIDTH-2];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// tb_spi_slave: mode-0 master model driving spi_slave; rx words checked through a scoreboard queue.
// Rev 1.0
module tb_spi_slave;

  logic       clk;
  logic       reset;
  logic       spi_clk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;
  logic [1:0] state;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] rx_q[$];
  logic [7:0] got;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .underrun (underrun),
    .state    (state)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!reset && rx_valid) begin
      if (rx_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rx_unexpected: got rx_valid with 0x%0h, want no pulse", rx_data);
      end else begin
        chk("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
      end
    end
  end

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Half spi_clk period is 8 clk cycles; miso is sampled on the rising spi_clk edge.
  task automatic xfer(input logic [7:0] m, input int nbits, output logic [7:0] rcv);
    rcv = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = m[7-i];
      repeat (8) @(negedge clk);
      spi_clk  = 1'b1;
      rcv[7-i] = miso;
      repeat (8) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    spi_clk = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    tx_data = 8'h00;
    tx_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 1);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_state", {30'd0, state}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // No tx loaded: master reads zeros, underrun sets
    chk("t4_underrun_before", {31'd0, underrun}, 0);
    rx_q.push_back(8'h96);
    cs_low();
    xfer(8'h96, 8, got);
    cs_high();
    chk("t4_miso_word", {24'd0, got}, 32'h00);
    chk("t4_underrun_after", {31'd0, underrun}, 1);

    // Single word with a preloaded tx byte
    load_tx(8'h5C);
    chk("t1_tx_ready_loaded", {31'd0, tx_ready}, 0);
    rx_q.push_back(8'hAB);
    cs_low();
    repeat (6) @(negedge clk);
    chk("t1_tx_ready_at_load", {31'd0, tx_ready}, 1);
    chk("t1_state_shift", {30'd0, state}, 2);
    xfer(8'hAB, 8, got);
    cs_high();
    chk("t1_miso_word", {24'd0, got}, 32'h5C);
    chk("t1_state_idle", {30'd0, state}, 0);

    // Back-to-back words, tx reloaded during the first word
    load_tx(8'h12);
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h34);
    cs_low();
    repeat (6) @(negedge clk);
    load_tx(8'h34);
    chk("t2_tx_ready_refill", {31'd0, tx_ready}, 0);
    xfer(8'h12, 8, got);
    chk("t2_miso_word0", {24'd0, got}, 32'h12);
    xfer(8'h34, 8, got);
    chk("t2_miso_word1", {24'd0, got}, 32'h34);
    cs_high();

    // Partial word aborted by cs, then a full word
    cs_low();
    xfer(8'hA5, 3, got);
    cs_high();
    chk("t3_state_abort", {30'd0, state}, 0);
    chk("t3_miso_abort", {31'd0, miso}, 0);
    chk("t3_rx_data_held", {24'd0, rx_data}, 32'h34);
    rx_q.push_back(8'hF0);
    cs_low();
    xfer(8'hF0, 8, got);
    cs_high();
    chk("t3_miso_word", {24'd0, got}, 32'h00);

    // Second load while the buffer is full is ignored
    load_tx(8'h11);
    load_tx(8'h22);
    chk("t5_tx_ready_full", {31'd0, tx_ready}, 0);
    rx_q.push_back(8'h5A);
    cs_low();
    xfer(8'h5A, 8, got);
    cs_high();
    chk("t5_miso_word", {24'd0, got}, 32'h11);
    chk("t5_underrun_sticky", {31'd0, underrun}, 1);

    // Reset mid-word, then a clean transfer
    cs_low();
    xfer(8'hC3, 4, got);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_miso", {31'd0, miso}, 0);
    chk("t6_rst_tx_ready", {31'd0, tx_ready}, 1);
    chk("t6_rst_rx_data", {24'd0, rx_data}, 0);
    chk("t6_rst_underrun", {31'd0, underrun}, 0);
    chk("t6_rst_state", {30'd0, state}, 0);
    @(negedge clk);
    reset = 1'b0;
    cs_high();
    chk("t6_rx_data_after", {24'd0, rx_data}, 0);
    rx_q.push_back(8'h3C);
    cs_low();
    xfer(8'h3C, 8, got);
    cs_high();
    chk("t6_miso_word", {24'd0, got}, 32'h00);
    chk("t6_rx_data_final", {24'd0, rx_data}, 32'h3C);

    repeat (20) @(negedge clk);
    chk("rx_q_drained", rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
